audio_codec_controller: RTL and testbench

// - Digital audio-interface controller for a WM8731-style codec running as serial-bus master.
// - Deserialises ADC samples into a stereo input FIFO.
// - Serialises stereo samples from an output FIFO to the DAC.
// - Generates the codec master clock AUD_XCK.
// - Sits between the top-level audio loopback/tone mixer and the codec pins.

---
 rtl/audio_codec_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_audio_codec_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_codec_controller.sv
// audio_codec_controller
//   Serial-bus master-side controller for a WM8731-style audio codec.
//   Deserialises ADC samples into a stereo input FIFO and serialises stereo
//   samples from an output FIFO onto the DAC line. Also generates AUD_XCK.
//
// Ports
//   CLOCK_50                 system clock, rising edge
//   RESETN                   asynchronous active-low reset
//   read_audio_in            pop one stereo pair from the input FIFO
//   write_audio_out          push one stereo pair into the output FIFO
//   left/right_channel_audio_out  sample pair to push
//   audio_in_available       input FIFO not empty
//   left/right_channel_audio_in   head pair of the input FIFO (0 when empty)
//   audio_out_allowed        output FIFO not full
//   AUD_ADCDAT               serial ADC data from the codec
//   AUD_BCLK/ADCLRCK/DACLRCK codec-driven clocks, only observed here
//   AUD_XCK                  codec master clock, CLOCK_50 / XCK_DIV
//   AUD_DACDAT               serial DAC data to the codec
module audio_codec_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int XCK_DIV    = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESETN,
  input  logic                  read_audio_in,
  input  logic                  write_audio_out,
  input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
  input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
  output logic                  audio_in_available,
  output logic [DATA_WIDTH-1:0] left_channel_audio_in,
  output logic [DATA_WIDTH-1:0] right_channel_audio_in,
  output logic                  audio_out_allowed,
  input  logic                  AUD_ADCDAT,
  inout  wire                   AUD_BCLK,
  inout  wire                   AUD_ADCLRCK,
  inout  wire                   AUD_DACLRCK,
  output logic                  AUD_XCK,
  output logic                  AUD_DACDAT
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = $clog2(DATA_WIDTH + 1);
  localparam int XW    = $clog2(XCK_DIV);
  localparam int XHALF = XCK_DIV / 2;

  // ---------------------------------------------------------------------------
  // Codec master clock
  // ---------------------------------------------------------------------------
  logic [XW-1:0] xck_cnt;

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      xck_cnt <= '0;
      AUD_XCK <= 1'b0;
    end else if (xck_cnt == XW'(XHALF - 1)) begin
      xck_cnt <= '0;
      AUD_XCK <= ~AUD_XCK;
    end else begin
      xck_cnt <= xck_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchronisers and edge detection for the codec-driven lines
  // ---------------------------------------------------------------------------
  logic [1:0] bclk_sync, adclrck_sync, daclrck_sync, adcdat_sync;
  logic       bclk_prev, adclrck_prev, daclrck_prev;

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      bclk_sync    <= '0;
      adclrck_sync <= '0;
      daclrck_sync <= '0;
      adcdat_sync  <= '0;
      bclk_prev    <= 1'b0;
      adclrck_prev <= 1'b0;
      daclrck_prev <= 1'b0;
    end else begin
      bclk_sync    <= {bclk_sync[0], AUD_BCLK};
      adclrck_sync <= {adclrck_sync[0], AUD_ADCLRCK};
      daclrck_sync <= {daclrck_sync[0], AUD_DACLRCK};
      adcdat_sync  <= {adcdat_sync[0], AUD_ADCDAT};
      bclk_prev    <= bclk_sync[1];
      adclrck_prev <= adclrck_sync[1];
      daclrck_prev <= daclrck_sync[1];
    end
  end

  logic bclk_rise, bclk_fall;
  logic adclrck_rise, adclrck_fall, adclrck_edge;
  logic daclrck_rise, daclrck_fall;

  assign bclk_rise    =  bclk_sync[1]    & ~bclk_prev;
  assign bclk_fall    = ~bclk_sync[1]    &  bclk_prev;
  assign adclrck_rise =  adclrck_sync[1] & ~adclrck_prev;
  assign adclrck_fall = ~adclrck_sync[1] &  adclrck_prev;
  assign adclrck_edge =  adclrck_rise | adclrck_fall;
  assign daclrck_rise =  daclrck_sync[1] & ~daclrck_prev;
  assign daclrck_fall = ~daclrck_sync[1] &  daclrck_prev;

  // ---------------------------------------------------------------------------
  // ADC deserialiser
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] adc_shift;
  logic [DATA_WIDTH-1:0] adc_left;
  logic [DATA_WIDTH-1:0] adc_word;
  logic [BW-1:0]         adc_cnt;
  logic                  adc_left_valid;
  logic                  adc_pair_done;

  // Bits are collected at the LSB end; a short half-frame is left-aligned
  // here so its missing LSBs read as zero.
  assign adc_word = adc_shift << (BW'(DATA_WIDTH) - adc_cnt);

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      adc_shift      <= '0;
      adc_cnt        <= '0;
      adc_left       <= '0;
      adc_left_valid <= 1'b0;
    end else if (adclrck_edge) begin
      adc_shift <= '0;
      adc_cnt   <= '0;
      if (adclrck_fall) begin
        adc_left       <= adc_word;
        adc_left_valid <= 1'b1;
      end
    end else if (bclk_rise && (adc_cnt < BW'(DATA_WIDTH))) begin
      adc_shift <= {adc_shift[DATA_WIDTH-2:0], adcdat_sync[1]};
      adc_cnt   <= adc_cnt + 1'b1;
    end
  end

  // A pair is complete only once a left word has been latched since reset.
  assign adc_pair_done = adclrck_rise & adc_left_valid;

  // ---------------------------------------------------------------------------
  // Input FIFO (ADC -> user), show-ahead read side
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] in_mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] in_mem_r [FIFO_DEPTH];
  logic [AW:0]           in_wr_ptr, in_rd_ptr;
  logic                  in_empty, in_full, in_push, in_pop;

  assign in_empty = (in_wr_ptr == in_rd_ptr);
  assign in_full  = (in_wr_ptr[AW] != in_rd_ptr[AW]) &&
                    (in_wr_ptr[AW-1:0] == in_rd_ptr[AW-1:0]);
  assign in_pop   = read_audio_in & ~in_empty;
  // A pop in the same cycle frees the slot being written, so push is allowed.
  assign in_push  = adc_pair_done & (~in_full | in_pop);

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (in_push) begin
      in_mem_l[in_wr_ptr[AW-1:0]] <= adc_left;
      in_mem_r[in_wr_ptr[AW-1:0]] <= adc_word;
    end
  end

  assign audio_in_available     = ~in_empty;
  assign left_channel_audio_in  = in_empty ? '0 : in_mem_l[in_rd_ptr[AW-1:0]];
  assign right_channel_audio_in = in_empty ? '0 : in_mem_r[in_rd_ptr[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Output FIFO (user -> DAC)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] out_mem_l [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_r [FIFO_DEPTH];
  logic [AW:0]           out_wr_ptr, out_rd_ptr;
  logic                  out_empty, out_full, out_push, out_pop;
  logic [DATA_WIDTH-1:0] out_head_l, out_head_r;

  assign out_empty  = (out_wr_ptr == out_rd_ptr);
  assign out_full   = (out_wr_ptr[AW] != out_rd_ptr[AW]) &&
                      (out_wr_ptr[AW-1:0] == out_rd_ptr[AW-1:0]);
  assign out_pop    = daclrck_rise & ~out_empty;
  assign out_push   = write_audio_out & (~out_full | out_pop);
  // Empty FIFO yields a zero pair, which is exactly the underrun payload.
  assign out_head_l = out_empty ? '0 : out_mem_l[out_rd_ptr[AW-1:0]];
  assign out_head_r = out_empty ? '0 : out_mem_r[out_rd_ptr[AW-1:0]];

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (out_push) begin
      out_mem_l[out_wr_ptr[AW-1:0]] <= left_channel_audio_out;
      out_mem_r[out_wr_ptr[AW-1:0]] <= right_channel_audio_out;
    end
  end

  assign audio_out_allowed = ~out_full;

  // ---------------------------------------------------------------------------
  // DAC serialiser
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] dac_shift;
  logic [DATA_WIDTH-1:0] dac_right;
  logic [BW-1:0]         dac_cnt;

  // dac_cnt counts bits already presented on AUD_DACDAT; the MSB goes out
  // with the LRCK edge itself, so an LRCK edge takes priority over a
  // coincident BCLK fall.
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      dac_shift  <= '0;
      dac_right  <= '0;
      dac_cnt    <= '0;
      AUD_DACDAT <= 1'b0;
    end else if (daclrck_rise) begin
      dac_right  <= out_head_r;
      dac_shift  <= out_head_l << 1;
      dac_cnt    <= BW'(1);
      AUD_DACDAT <= out_head_l[DATA_WIDTH-1];
    end else if (daclrck_fall) begin
      dac_shift  <= dac_right << 1;
      dac_cnt    <= BW'(1);
      AUD_DACDAT <= dac_right[DATA_WIDTH-1];
    end else if (bclk_fall) begin
      if (dac_cnt < BW'(DATA_WIDTH)) begin
        dac_shift  <= dac_shift << 1;
        dac_cnt    <= dac_cnt + 1'b1;
        AUD_DACDAT <= dac_shift[DATA_WIDTH-1];
      end else begin
        AUD_DACDAT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_audio_codec_controller.sv
// Self-checking bench for audio_codec_controller: a codec model drives BCLK,
// both LRCKs and ADCDAT, and captures DACDAT on BCLK rising edges.
module tb_audio_codec_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_tb = 1'b0, wr_tb = 1'b0;
  logic [31:0] l_tb = '0, r_tb = '0;
  logic        bclk = 1'b1, adclrck = 1'b0, daclrck = 1'b0, adcdat = 1'b0;
  logic        loop = 1'b0;

  logic        rd_sig, wr_sig;
  logic [31:0] lo_sig, ro_sig;
  logic        in_avail, out_allowed, xck, dacdat;
  logic [31:0] left_in, right_in;
  wire         bclk_w, adclrck_w, daclrck_w;

  assign bclk_w    = bclk;
  assign adclrck_w = adclrck;
  assign daclrck_w = daclrck;

  assign rd_sig = loop ? (in_avail & out_allowed) : rd_tb;
  assign wr_sig = loop ? (in_avail & out_allowed) : wr_tb;
  assign lo_sig = loop ? left_in  : l_tb;
  assign ro_sig = loop ? right_in : r_tb;

  always #5 clk = ~clk;

  audio_codec_controller #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .XCK_DIV(4)) dut (
    .CLOCK_50               (clk),
    .RESETN                 (rst_n),
    .read_audio_in          (rd_sig),
    .write_audio_out        (wr_sig),
    .left_channel_audio_out (lo_sig),
    .right_channel_audio_out(ro_sig),
    .audio_in_available     (in_avail),
    .left_channel_audio_in  (left_in),
    .right_channel_audio_in (right_in),
    .audio_out_allowed      (out_allowed),
    .AUD_ADCDAT             (adcdat),
    .AUD_BCLK               (bclk_w),
    .AUD_ADCLRCK            (adclrck_w),
    .AUD_DACLRCK            (daclrck_w),
    .AUD_XCK                (xck),
    .AUD_DACDAT             (dacdat)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected pairs {left,right} for each FIFO.
  logic [63:0] in_q[$];
  logic [63:0] out_q[$];
  logic [63:0] pend = '0;
  logic        pend_valid = 1'b0;
  logic        hold_en = 1'b0;
  logic [63:0] hold_pair = '0;

  int mon_cnt = 0;
  logic mon_en = 1'b0;
  always @(negedge clk) if (mon_en && out_allowed) mon_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_out(input logic [31:0] l, input logic [31:0] r);
    check("out_allowed_before_push", 32'(out_allowed), 32'(out_q.size() < 8));
    wr_tb = 1'b1; l_tb = l; r_tb = r;
    @(negedge clk);
    wr_tb = 1'b0;
    if (out_q.size() < 8) out_q.push_back({l, r});
  endtask

  task automatic drain_in();
    logic [63:0] p;
    while (in_q.size() > 0) begin
      p = in_q.pop_front();
      check("in_available", 32'(in_avail), 32'd1);
      check("left_in", left_in, p[63:32]);
      check("right_in", right_in, p[31:0]);
      rd_tb = 1'b1;
      @(negedge clk);
      rd_tb = 1'b0;
    end
    check("in_available_empty", 32'(in_avail), 32'd0);
    check("left_in_empty", left_in, 32'd0);
    check("right_in_empty", right_in, 32'd0);
  endtask

  // One LRCK frame of nb bits per half; the frame starts with the LRCK rise.
  task automatic frame(input logic [31:0] al, input logic [31:0] ar,
                       input logic [31:0] el, input logic [31:0] er, input int nb);
    logic [63:0] p;
    logic [31:0] w, dmask, cap_l, cap_r;
    int extra;
    p = '0;
    if (out_q.size() > 0) p = out_q.pop_front();
    if (hold_en && out_q.size() < 8) out_q.push_back(hold_pair);
    if (pend_valid && in_q.size() < 8) in_q.push_back(pend);
    if (loop) while (in_q.size() > 0 && out_q.size() < 8) out_q.push_back(in_q.pop_front());
    dmask = (nb >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nb);
    cap_l = '0; cap_r = '0; extra = 0;
    for (int h = 0; h < 2; h++) begin
      w = (h == 0) ? al : ar;
      for (int b = 0; b < nb; b++) begin
        bclk = 1'b0;
        if (b == 0) begin adclrck = (h == 0); daclrck = (h == 0); end
        adcdat = (b < 32) ? w[5'(31 - b)] : 1'b1;
        repeat (8) @(negedge clk);
        if (hold_en) begin wr_tb = 1'b0; hold_en = 1'b0; end
        bclk = 1'b1;
        if (b < 32) begin
          if (h == 0) cap_l[5'(31 - b)] = dacdat;
          else        cap_r[5'(31 - b)] = dacdat;
        end else if (dacdat) begin
          extra++;
        end
        repeat (8) @(negedge clk);
      end
    end
    check("dac_left", cap_l, p[63:32] & dmask);
    check("dac_right", cap_r, p[31:0] & dmask);
    if (nb > 32) check("dac_tail_zero", 32'(extra), 32'd0);
    pend = {el, er};
    pend_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bclk = 1'b1; adclrck = 1'b0; daclrck = 1'b0; adcdat = 1'b0;
    rd_tb = 1'b0; wr_tb = 1'b0;
    in_q.delete(); out_q.delete();
    pend_valid = 1'b0; hold_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] adc_l, adc_r;
    int          nb;
    logic        push_dac;
    logic [31:0] dac_l, dac_r;
    logic [31:0] exp_l, exp_r;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int m0;
    vecs[0] = '{32'hA5A5_0001, 32'h0000_FFFF, 32, 1'b1, 32'h8000_0001, 32'h7FFF_FFFE,
                32'hA5A5_0001, 32'h0000_FFFF};
    vecs[1] = '{32'h1234_5678, 32'h9ABC_DEF0, 32, 1'b0, 32'h0, 32'h0,
                32'h1234_5678, 32'h9ABC_DEF0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h8000_0001, 16, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                32'hFFFF_0000, 32'h8000_0000};
    vecs[3] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 36, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0,
                32'h0F0F_0F0F, 32'hF0F0_F0F0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_available", 32'(in_avail), 32'd0);
    check("rst_out_allowed", 32'(out_allowed), 32'd1);
    check("rst_left_in", left_in, 32'd0);
    check("rst_right_in", right_in, 32'd0);
    check("rst_xck", 32'(xck), 32'd0);
    check("rst_dacdat", 32'(dacdat), 32'd0);
    rst_n = 1'b1;

    // AUD_XCK toggles every 2 cycles from reset release
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("xck_phase", 32'(xck), 32'((k >> 1) & 1));
    end

    // Table-driven ADC/DAC frames
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].push_dac) push_out(vecs[i].dac_l, vecs[i].dac_r);
      frame(vecs[i].adc_l, vecs[i].adc_r, vecs[i].exp_l, vecs[i].exp_r, vecs[i].nb);
      drain_in();
    end
    frame('0, '0, '0, '0, 32);
    drain_in();

    // Input overflow: 9 completed frames, 9th dropped
    do_reset();
    for (int i = 1; i <= 10; i++)
      frame(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i),
            32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32);
    check("ovf_in_available", 32'(in_avail), 32'd1);
    drain_in();

    // Output FIFO full, then push concurrent with the DAC pop
    do_reset();
    for (int i = 1; i <= 8; i++) push_out(32'h3000_0000 + 32'(i), 32'h4000_0000 + 32'(i));
    check("out_allowed_full", 32'(out_allowed), 32'd0);
    push_out(32'hBAD0_0000, 32'hBAD0_0001);
    hold_pair = {32'h3000_0009, 32'h4000_0009};
    l_tb = 32'h3000_0009; r_tb = 32'h4000_0009; wr_tb = 1'b1; hold_en = 1'b1;
    m0 = mon_cnt; mon_en = 1'b1;
    frame(32'h5000_0001, 32'h6000_0001, 32'h5000_0001, 32'h6000_0001, 32);
    mon_en = 1'b0;
    check("allowed_stays_low", 32'(mon_cnt - m0), 32'd0);
    check("out_allowed_after_concurrent", 32'(out_allowed), 32'(out_q.size() < 8));
    for (int i = 2; i <= 10; i++)
      frame(32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i),
            32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i), 32);
    drain_in();

    // Loopback with read/write strobed while data is available
    do_reset();
    loop = 1'b1;
    for (int i = 1; i <= 5; i++)
      frame(32'h7100_0000 + 32'(i), 32'h7200_0000 + 32'(i),
            32'h7100_0000 + 32'(i), 32'h7200_0000 + 32'(i), 32);
    loop = 1'b0;
    frame(32'h7300_0006, 32'h7400_0006, 32'h7300_0006, 32'h7400_0006, 32);
    frame(32'h7300_0007, 32'h7400_0007, 32'h7300_0007, 32'h7400_0007, 32);
    drain_in();

    // Reset in the middle of a frame with traffic in both FIFOs
    push_out(32'hAAAA_5555, 32'h5555_AAAA);
    push_out(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    frame(32'h0101_0101, 32'h0202_0202, 32'h0101_0101, 32'h0202_0202, 32);
    bclk = 1'b0; adclrck = 1'b1; daclrck = 1'b1; adcdat = 1'b1;
    for (int b = 0; b < 5; b++) begin
      bclk = 1'b0; repeat (8) @(negedge clk);
      bclk = 1'b1; repeat (8) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_available", 32'(in_avail), 32'd0);
    check("mid_rst_out_allowed", 32'(out_allowed), 32'd1);
    check("mid_rst_dacdat", 32'(dacdat), 32'd0);
    check("mid_rst_xck", 32'(xck), 32'd0);
    check("mid_rst_left_in", left_in, 32'd0);
    do_reset();
    frame(32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0002, 32);
    drain_in();
    frame(32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0004, 32);
    drain_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
